// File: rtl/npu_result_pkg.sv
// rtl/npu_result_pkg.sv - shared types and defaults for the NPU result buffer
package npu_result_pkg;

    localparam int RESULT_DATA_W = 32;
    localparam int RESULT_DEPTH  = 64;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        DRAIN = 2'd1,
        CLEAR = 2'd2
    } state_t;

endpackage

// File: rtl/npu_result_arbiter.sv
// rtl/npu_result_arbiter.sv - fixed-priority write-channel arbiter (lowest index wins)
//
// Ports:
//   req   - per-channel request vector
//   en    - arbitration enable; when low no grant is issued
//   grant - one-hot grant (all zeros when nothing wins)
//   sel   - index of the winning channel (0 when none)
//   valid - a grant was issued this cycle
module npu_result_arbiter #(
    parameter int NUM_CH = 4,
    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic [NUM_CH-1:0] req,
    input  logic              en,
    output logic [NUM_CH-1:0] grant,
    output logic [IDX_W-1:0]  sel,
    output logic              valid
);

    always_comb begin
        grant = '0;
        sel   = '0;
        valid = 1'b0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (en && req[i] && !valid) begin
                grant[i] = 1'b1;
                sel      = i[IDX_W-1:0];
                valid    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/npu_result_buffer.sv
// rtl/npu_result_buffer.sv - multi-channel NPU result memory with read, drain and clear engines
//
// Optional feature macro: NPU_RESULT_BUF_STATS_EN (adds conflict_cnt output).
//
// Ports:
//   clk, rst                    - clock, asynchronous active-high reset
//   wr_en/wr_addr/wr_data       - NUM_CH packed write channels
//   wr_grant                    - combinational per-channel commit indication
//   rd_en/rd_addr               - random-access read request (IDLE only)
//   rd_data/rd_valid            - registered read result
//   drain_start/clear_start     - engine start pulses (IDLE only, clear wins)
//   out_valid/out_ready/out_data/out_last - drain stream
//   busy, done                  - engine status and end-of-operation pulse
//   count                       - high-water mark of committed writes
//   conflict_cnt                - saturating count of refused requests (stats build)
module npu_result_buffer
    import npu_result_pkg::*;
#(
    parameter int DATA_W = RESULT_DATA_W,
    parameter int DEPTH  = RESULT_DEPTH,
    parameter int NUM_CH = 4,
    localparam int ADDR_W = $clog2(DEPTH)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NUM_CH-1:0]        wr_en,
    input  logic [NUM_CH*ADDR_W-1:0] wr_addr,
    input  logic [NUM_CH*DATA_W-1:0] wr_data,
    output logic [NUM_CH-1:0]        wr_grant,
    input  logic                     rd_en,
    input  logic [ADDR_W-1:0]        rd_addr,
    output logic [DATA_W-1:0]        rd_data,
    output logic                     rd_valid,
    input  logic                     drain_start,
    input  logic                     clear_start,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DATA_W-1:0]        out_data,
    output logic                     out_last,
    output logic                     busy,
    output logic                     done,
    output logic [ADDR_W:0]          count
`ifdef NPU_RESULT_BUF_STATS_EN
    ,
    output logic [15:0]              conflict_cnt
`endif
);

    localparam int IDX_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

    logic [DATA_W-1:0] mem [DEPTH];

    state_t state, state_nxt;

    logic [ADDR_W-1:0] ptr;
    logic [ADDR_W-1:0] clr_ptr;

    logic [IDX_W-1:0]  arb_sel;
    logic              arb_valid;
    logic              in_idle;

    logic [ADDR_W-1:0] ch_addr [NUM_CH];
    logic [DATA_W-1:0] ch_data [NUM_CH];
    logic [ADDR_W-1:0] sel_addr;
    logic [DATA_W-1:0] sel_data;
    logic [ADDR_W:0]   sel_hw;

    logic              mem_we;
    logic [ADDR_W-1:0] mem_waddr;
    logic [DATA_W-1:0] mem_wdata;

    logic              drain_hs;
    logic              clr_last;
    logic              go_clear;
    logic              go_drain;
    logic              go_empty;

    npu_result_arbiter #(
        .NUM_CH (NUM_CH)
    ) u_arb (
        .req   (wr_en),
        .en    (in_idle),
        .grant (wr_grant),
        .sel   (arb_sel),
        .valid (arb_valid)
    );

    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            ch_addr[i] = wr_addr[i*ADDR_W +: ADDR_W];
            ch_data[i] = wr_data[i*DATA_W +: DATA_W];
        end
    end

    assign sel_addr = ch_addr[arb_sel];
    assign sel_data = ch_data[arb_sel];
    assign sel_hw   = {1'b0, sel_addr} + {{ADDR_W{1'b0}}, 1'b1};

    assign in_idle  = (state == IDLE);
    assign busy     = !in_idle;
    assign drain_hs = (state == DRAIN) && out_valid && out_ready;
    assign clr_last = (state == CLEAR) && (clr_ptr == ADDR_W'(DEPTH - 1));
    assign go_clear = in_idle && clear_start;
    assign go_drain = in_idle && !clear_start && drain_start && (count != '0);
    assign go_empty = in_idle && !clear_start && drain_start && (count == '0);

    // Next-state logic
    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (go_clear) begin
                    state_nxt = CLEAR;
                end else if (go_drain) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                if (drain_hs && out_last) begin
                    state_nxt = IDLE;
                end
            end
            CLEAR: begin
                if (clr_last) begin
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Single memory write port shared by the clear engine and the arbiter winner;
    // the arbiter is disabled outside IDLE so the two never collide.
    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = sel_addr;
        mem_wdata = sel_data;
        if (state == CLEAR) begin
            mem_we    = 1'b1;
            mem_waddr = clr_ptr;
            mem_wdata = '0;
        end else if (arb_valid) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Read port, drain datapath, clear pointer, high-water mark and done pulse
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_data   <= '0;
            rd_valid  <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            out_last  <= 1'b0;
            done      <= 1'b0;
            count     <= '0;
            ptr       <= '0;
            clr_ptr   <= '0;
        end else begin
            done     <= 1'b0;
            rd_valid <= 1'b0;

            if (in_idle && rd_en) begin
                rd_data  <= mem[rd_addr];
                rd_valid <= 1'b1;
            end

            if (arb_valid && (sel_hw > count)) begin
                count <= sel_hw;
            end

            if (go_clear) begin
                clr_ptr <= '0;
            end else if (go_drain) begin
                ptr       <= '0;
                out_valid <= 1'b1;
                out_data  <= mem[0];
                out_last  <= (count == {{ADDR_W{1'b0}}, 1'b1});
            end else if (go_empty) begin
                done <= 1'b1;
            end

            if (drain_hs) begin
                if (out_last) begin
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                    done      <= 1'b1;
                end else begin
                    // Writes are locked out while draining, so reading ahead is safe.
                    ptr      <= ptr + 1'b1;
                    out_data <= mem[ptr + 1'b1];
                    out_last <= (({1'b0, ptr} + (ADDR_W+1)'(2)) == count);
                end
            end

            if (state == CLEAR) begin
                clr_ptr <= clr_ptr + 1'b1;
                if (clr_last) begin
                    count <= '0;
                    done  <= 1'b1;
                end
            end
        end
    end

`ifdef NPU_RESULT_BUF_STATS_EN
    logic [16:0] losses;
    logic [16:0] conflict_sum;

    always_comb begin
        losses = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            losses = losses + 17'(wr_en[i] & ~wr_grant[i]);
        end
        conflict_sum = {1'b0, conflict_cnt} + losses;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            conflict_cnt <= '0;
        end else if (clr_last) begin
            conflict_cnt <= '0;
        end else if (conflict_sum[16]) begin
            conflict_cnt <= 16'hFFFF;
        end else begin
            conflict_cnt <= conflict_sum[15:0];
        end
    end
`endif

endmodule

// File: tb/tb_npu_result_buffer.sv
// tb/tb_npu_result_buffer.sv - directed self-checking bench for npu_result_buffer
module tb_npu_result_buffer;

    localparam int DW = 32;
    localparam int AW = 6;
    localparam int NC = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [NC-1:0] wr_en;
    logic [NC*AW-1:0] wr_addr;
    logic [NC*DW-1:0] wr_data;
    logic [NC-1:0] wr_grant;
    logic          rd_en;
    logic [AW-1:0] rd_addr;
    logic [DW-1:0] rd_data;
    logic          rd_valid;
    logic          drain_start;
    logic          clear_start;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_data;
    logic          out_last;
    logic          busy;
    logic          done;
    logic [AW:0]   count;
`ifdef NPU_RESULT_BUF_STATS_EN
    logic [15:0]   conflict_cnt;
`endif

    int nvec = 0;
    int nerr = 0;

    always #5 clk = ~clk;

    npu_result_buffer dut (
        .clk         (clk),
        .rst         (rst),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .wr_grant    (wr_grant),
        .rd_en       (rd_en),
        .rd_addr     (rd_addr),
        .rd_data     (rd_data),
        .rd_valid    (rd_valid),
        .drain_start (drain_start),
        .clear_start (clear_start),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_last    (out_last),
        .busy        (busy),
        .done        (done),
        .count       (count)
`ifdef NPU_RESULT_BUF_STATS_EN
        ,
        .conflict_cnt(conflict_cnt)
`endif
    );

    typedef struct {
        logic [3:0]   we;
        logic [23:0]  wa;
        logic [127:0] wd;
        logic         re;
        logic [5:0]   ra;
        logic [3:0]   gnt;
        logic [31:0]  rd;
        logic [6:0]   cnt;
    } vec_t;

    vec_t vec [14];

    function automatic vec_t mkv(input logic [3:0] we, input logic [23:0] wa,
                                 input logic [127:0] wd, input logic re,
                                 input logic [5:0] ra, input logic [3:0] gnt,
                                 input logic [31:0] rd, input logic [6:0] cnt);
        vec_t v;
        v.we = we; v.wa = wa; v.wd = wd; v.re = re; v.ra = ra;
        v.gnt = gnt; v.rd = rd; v.cnt = cnt;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic write1(input int ch, input logic [5:0] a, input logic [31:0] d,
                          input logic [3:0] exp_gnt);
        @(negedge clk);
        wr_en = '0;
        wr_en[ch] = 1'b1;
        wr_addr[ch*AW +: AW] = a;
        wr_data[ch*DW +: DW] = d;
        #1 chk("write_grant", 64'(wr_grant), 64'(exp_gnt));
        @(posedge clk);
        #1 wr_en = '0;
    endtask

    task automatic read1(input logic [5:0] a, input logic [31:0] exp);
        @(negedge clk);
        rd_en = 1'b1;
        rd_addr = a;
        @(posedge clk);
        #1;
        chk("read_valid", 64'(rd_valid), 64'd1);
        chk("read_data", 64'(rd_data), 64'(exp));
        rd_en = 1'b0;
    endtask

    logic [3:0]  rp [4];
    logic [31:0] ed [4];
    logic        el [4];

    initial begin
        rst = 1'b1;
        wr_en = '0; wr_addr = '0; wr_data = '0;
        rd_en = 1'b0; rd_addr = '0;
        drain_start = 1'b0; clear_start = 1'b0; out_ready = 1'b0;

        vec[0]  = mkv(4'b0001, {6'd0, 6'd0, 6'd0, 6'd0}, {96'h0, 32'hDEADBEEF}, 0, 0, 4'b0001, 0, 7'd1);
        vec[1]  = mkv(4'b0100, {6'd0, 6'd1, 6'd0, 6'd0}, {32'h0, 32'h12345678, 64'h0}, 0, 0, 4'b0100, 0, 7'd2);
        vec[2]  = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd0, 4'b0000, 32'hDEADBEEF, 7'd2);
        vec[3]  = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd1, 4'b0000, 32'h12345678, 7'd2);
        vec[4]  = mkv(4'b1010, {6'd9, 6'd0, 6'd5, 6'd0}, {32'hA3, 32'h0, 32'hA1, 32'h0}, 0, 0, 4'b0010, 0, 7'd6);
        vec[5]  = mkv(4'b1000, {6'd9, 6'd0, 6'd0, 6'd0}, {32'hA3, 96'h0}, 0, 0, 4'b1000, 0, 7'd10);
        vec[6]  = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd5, 4'b0000, 32'hA1, 7'd10);
        vec[7]  = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd9, 4'b0000, 32'hA3, 7'd10);
        vec[8]  = mkv(4'b0001, {6'd0, 6'd0, 6'd0, 6'd1}, {96'h0, 32'h55}, 1, 6'd1, 4'b0001, 32'h12345678, 7'd10);
        vec[9]  = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd1, 4'b0000, 32'h55, 7'd10);
        vec[10] = mkv(4'b0110, {6'd0, 6'd3, 6'd63, 6'd0}, {32'h0, 32'h0, 32'hCAFE, 32'h0}, 0, 0, 4'b0010, 0, 7'd64);
        vec[11] = mkv(4'b0100, {6'd0, 6'd3, 6'd0, 6'd0}, {32'h0, 32'h77, 64'h0}, 0, 0, 4'b0100, 0, 7'd64);
        vec[12] = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd63, 4'b0000, 32'hCAFE, 7'd64);
        vec[13] = mkv(4'b0000, 24'h0, 128'h0, 1, 6'd3, 4'b0000, 32'h77, 7'd64);

        repeat (3) @(posedge clk);
        #1;
        chk("rst_count", 64'(count), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_rd_valid", 64'(rd_valid), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 14; i++) begin
            @(negedge clk);
            wr_en = vec[i].we; wr_addr = vec[i].wa; wr_data = vec[i].wd;
            rd_en = vec[i].re; rd_addr = vec[i].ra;
            #1 chk($sformatf("vec%0d_grant", i), 64'(wr_grant), 64'(vec[i].gnt));
            @(posedge clk);
            #1;
            chk($sformatf("vec%0d_count", i), 64'(count), 64'(vec[i].cnt));
            chk($sformatf("vec%0d_rd_valid", i), 64'(rd_valid), 64'(vec[i].re));
            if (vec[i].re) chk($sformatf("vec%0d_rd_data", i), 64'(rd_data), 64'(vec[i].rd));
            wr_en = '0; rd_en = 1'b0;
        end
`ifdef NPU_RESULT_BUF_STATS_EN
        chk("conflict_cnt", 64'(conflict_cnt), 64'd2);
`endif

        // Clear: DEPTH busy cycles, a drain_start inside is ignored
        @(negedge clk);
        clear_start = 1'b1;
        @(posedge clk);
        #1 clear_start = 1'b0;
        for (int i = 0; i < 64; i++) begin
            chk("clear_busy", 64'(busy), 64'd1);
            if (i == 10) drain_start = 1'b1;
            if (i == 11) drain_start = 1'b0;
            @(posedge clk);
            #1;
        end
        chk("clear_done", 64'(done), 64'd1);
        chk("clear_idle", 64'(busy), 64'd0);
        chk("clear_count", 64'(count), 64'd0);
        chk("clear_no_drain", 64'(out_valid), 64'd0);
`ifdef NPU_RESULT_BUF_STATS_EN
        chk("conflict_cleared", 64'(conflict_cnt), 64'd0);
`endif
        read1(6'd0, 32'h0);
        read1(6'd9, 32'h0);
        read1(6'd63, 32'h0);

        // Drain with nothing written
        @(negedge clk);
        drain_start = 1'b1;
        @(posedge clk);
        #1 drain_start = 1'b0;
        chk("empty_drain_done", 64'(done), 64'd1);
        chk("empty_drain_valid", 64'(out_valid), 64'd0);
        chk("empty_drain_busy", 64'(busy), 64'd0);

        // Drain of 3 words with a stall
        write1(0, 6'd0, 32'h11, 4'b0001);
        write1(1, 6'd1, 32'h22, 4'b0010);
        write1(3, 6'd2, 32'h33, 4'b1000);
        chk("drain_count", 64'(count), 64'd3);
        rp[0] = 1; rp[1] = 0; rp[2] = 1; rp[3] = 1;
        ed[0] = 32'h11; ed[1] = 32'h22; ed[2] = 32'h22; ed[3] = 32'h33;
        el[0] = 0; el[1] = 0; el[2] = 0; el[3] = 1;
        @(negedge clk);
        drain_start = 1'b1;
        @(posedge clk);
        #1 drain_start = 1'b0;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            out_ready = rp[k][0];
            if (k == 1) begin
                wr_en = 4'b0001;
                wr_addr = '0;
                wr_data = {96'h0, 32'h99};
            end
            #1;
            chk($sformatf("drain%0d_valid", k), 64'(out_valid), 64'd1);
            chk($sformatf("drain%0d_data", k), 64'(out_data), 64'(ed[k]));
            chk($sformatf("drain%0d_last", k), 64'(out_last), 64'(el[k]));
            if (k == 1) chk("drain_write_grant", 64'(wr_grant), 64'd0);
            @(posedge clk);
            #1 wr_en = '0;
        end
        out_ready = 1'b0;
        chk("drain_done", 64'(done), 64'd1);
        chk("drain_end_valid", 64'(out_valid), 64'd0);
        chk("drain_end_busy", 64'(busy), 64'd0);
        chk("drain_end_count", 64'(count), 64'd3);
        @(posedge clk);
        #1 chk("drain_done_pulse", 64'(done), 64'd0);
        read1(6'd0, 32'h11);

        // Asynchronous reset in the middle of a drain
        @(negedge clk);
        drain_start = 1'b1;
        @(posedge clk);
        #1 drain_start = 1'b0;
        chk("abort_valid_before", 64'(out_valid), 64'd1);
        #2 rst = 1'b1;
        #1;
        chk("abort_valid", 64'(out_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_count", 64'(count), 64'd0);
        @(negedge clk);
        rst = 1'b0;
        write1(1, 6'd4, 32'h44, 4'b0010);
        chk("post_abort_count", 64'(count), 64'd5);
        read1(6'd4, 32'h44);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
